// File: rtl/cci_mpf_prim_lutram_multiport_init.sv
// Multi-write/multi-read LUTRAM: replicated single-write banks plus a live-value table, self-initialised after reset.
// Optional sticky write-collision flag: define CCI_MPF_LUTRAM_MULTIPORT_CONFLICT_CHECK_EN.
module cci_mpf_prim_lutram_multiport_init #(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_READERS = 2,
  parameter int N_WRITERS = 2,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = {N_DATA_BITS{1'b0}},
  parameter READ_DURING_WRITE = "OLD_DATA"
) (
  input  logic clk,
  input  logic reset,
  output logic rdy,
  input  logic [N_READERS-1:0][$clog2(N_ENTRIES)-1:0] raddr,
  output logic [N_READERS-1:0][N_DATA_BITS-1:0] rdata,
  input  logic [N_WRITERS-1:0][$clog2(N_ENTRIES)-1:0] waddr,
  input  logic [N_WRITERS-1:0] wen,
  input  logic [N_WRITERS-1:0][N_DATA_BITS-1:0] wdata,
  output logic wconflict
);

  localparam int AW = $clog2(N_ENTRIES);
  localparam int DW = (N_DATA_BITS < 2) ? 2 : N_DATA_BITS;
  localparam int LW = (N_WRITERS < 2) ? 1 : $clog2(N_WRITERS);
  localparam bit OLD_MODE = (READ_DURING_WRITE == "OLD_DATA");
  localparam bit NEW_MODE = (READ_DURING_WRITE == "NEW_DATA");

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          rdy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= {AW{1'b0}};
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(N_ENTRIES - 1)) begin
            state_q <= ST_READY;
            rdy_q   <= 1'b1;
          end else begin
            state_q <= ST_INIT;
            rdy_q   <= 1'b0;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= {AW{1'b0}};
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdy = rdy_q;

  // Effective write ports: the init sequencer borrows writer 0 and masks user writes
  logic [N_WRITERS-1:0]         ewe_s;
  logic [N_WRITERS-1:0][AW-1:0] ewa_s;
  logic [N_WRITERS-1:0][DW-1:0] ewd_s;

  always_comb begin
    ewe_s = {N_WRITERS{1'b0}};
    ewa_s = waddr;
    for (int w = 0; w < N_WRITERS; w++) begin
      ewd_s[w] = DW'(wdata[w]);
    end
    if (state_q == ST_READY) begin
      ewe_s = wen;
    end else begin
      ewe_s[0] = 1'b1;
      ewa_s[0] = cnt_q;
      ewd_s[0] = DW'(INIT_VALUE);
    end
  end

  // Commit ports (drive banks and LVT) and forwarding ports (bypass into rdata)
  logic [N_WRITERS-1:0]         mwe_s, fwe_s;
  logic [N_WRITERS-1:0][AW-1:0] mwa_s, fwa_s;
  logic [N_WRITERS-1:0][DW-1:0] mwd_s, fwd_s;

  if (OLD_MODE) begin : g_old
    logic [N_WRITERS-1:0]         pwe_q;
    logic [N_WRITERS-1:0][AW-1:0] pwa_q;
    logic [N_WRITERS-1:0][DW-1:0] pwd_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pwe_q <= {N_WRITERS{1'b0}};
      end else begin
        pwe_q <= ewe_s;
      end
      pwa_q <= ewa_s;
      pwd_q <= ewd_s;
    end

    assign mwe_s = pwe_q;
    assign mwa_s = pwa_q;
    assign mwd_s = pwd_q;
    assign fwe_s = pwe_q;
    assign fwa_s = pwa_q;
    assign fwd_s = pwd_q;
  end else begin : g_direct
    assign mwe_s = ewe_s;
    assign mwa_s = ewa_s;
    assign mwd_s = ewd_s;
    assign fwe_s = NEW_MODE ? ewe_s : {N_WRITERS{1'b0}};
    assign fwa_s = ewa_s;
    assign fwd_s = ewd_s;
  end

  logic [N_WRITERS-1:0][N_READERS-1:0][DW-1:0] bank_rd_s;

  for (genvar w = 0; w < N_WRITERS; w++) begin : g_wr
    for (genvar p = 0; p < N_READERS; p++) begin : g_rd
      (* ramstyle = "MLAB, no_rw_check" *) logic [DW-1:0] mem_q [N_ENTRIES];

      always_ff @(posedge clk) begin
        if (mwe_s[w]) begin
          mem_q[mwa_s[w]] <= mwd_s[w];
        end
      end

      assign bank_rd_s[w][p] = mem_q[raddr[p]];
    end
  end

  logic [N_READERS-1:0][LW-1:0] lvt_rd_s;

  if (N_WRITERS > 1) begin : g_lvt
    logic [N_ENTRIES-1:0][LW-1:0] lvt_q, lvt_d;

    // Later writers overwrite earlier ones, so the highest-index writer owns a collided entry
    always_comb begin
      lvt_d = lvt_q;
      for (int w = 0; w < N_WRITERS; w++) begin
        lvt_d[mwa_s[w]] = mwe_s[w] ? LW'(w) : lvt_d[mwa_s[w]];
      end
    end

    always_ff @(posedge clk) begin
      lvt_q <= lvt_d;
    end

    for (genvar p = 0; p < N_READERS; p++) begin : g_lvt_rd
      assign lvt_rd_s[p] = lvt_q[raddr[p]];
    end
  end else begin : g_no_lvt
    assign lvt_rd_s = {(N_READERS * LW){1'b0}};
  end

  logic [N_READERS-1:0][DW-1:0] rd_s;

  always_comb begin
    for (int p = 0; p < N_READERS; p++) begin
      rd_s[p] = bank_rd_s[lvt_rd_s[p]][p];
      for (int w = 0; w < N_WRITERS; w++) begin
        rd_s[p] = (fwe_s[w] && (fwa_s[w] == raddr[p])) ? fwd_s[w] : rd_s[p];
      end
    end
  end

  for (genvar p = 0; p < N_READERS; p++) begin : g_rdata
    assign rdata[p] = rd_s[p][N_DATA_BITS-1:0];
  end

  if (DW > N_DATA_BITS) begin : g_pad
    logic [N_READERS-1:0] unused_hi_s;
    for (genvar p = 0; p < N_READERS; p++) begin : g_pad_rd
      assign unused_hi_s[p] = ^rd_s[p][DW-1:N_DATA_BITS];
    end
  end

`ifdef CCI_MPF_LUTRAM_MULTIPORT_CONFLICT_CHECK_EN
  logic conflict_s;
  logic wconflict_q;

  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < N_WRITERS; i++) begin
      for (int j = i + 1; j < N_WRITERS; j++) begin
        conflict_s = conflict_s | (wen[i] & wen[j] & (waddr[i] == waddr[j]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wconflict_q <= 1'b0;
    end else if ((state_q == ST_READY) && conflict_s) begin
      wconflict_q <= 1'b1;
    end else begin
      wconflict_q <= wconflict_q;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_READY)) begin
      for (int i = 0; i < N_WRITERS; i++) begin
        for (int j = i + 1; j < N_WRITERS; j++) begin
          if (wen[i] && wen[j] && (waddr[i] == waddr[j])) begin
            $error("lutram write collision: writers %0d and %0d at address %0d", i, j, waddr[i]);
          end
        end
      end
    end
  end
`endif

  assign wconflict = wconflict_q;
`else
  assign wconflict = 1'b0;
`endif

endmodule

// File: doc/cci_mpf_prim_lutram_multiport_init.md
Name: cci_mpf_prim_lutram_multiport_init

Overview:
- Multi-write, multi-read LUTRAM built from replicated single-write MLAB banks plus a live-value table (LVT) that selects the bank holding the most recent write.
- Initialises every entry to a constant after reset and signals readiness.
- Serves MPF shared tables (e.g. VTP, WRO hash tables) that need more than one independent writer per cycle.

Parameters:
- N_ENTRIES, 32: table depth; power of 2, minimum 2.
- N_DATA_BITS, 64: entry width; 1 permitted (internally widened to 2).
- N_READERS, 2: number of read ports, minimum 1.
- N_WRITERS, 2: number of write ports, minimum 1; a value of 1 degenerates to no LVT.
- INIT_VALUE, N_DATA_BITS'(0): value written to every entry after reset.
- READ_DURING_WRITE, "OLD_DATA": one of "OLD_DATA", "NEW_DATA" or "DONT_CARE"; applies to every reader/writer pair.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rdy  out  1  high once initialisation completes; stays high until the next reset.
- raddr  in  [N_READERS] x $clog2(N_ENTRIES)  read address per port.
- rdata  out  [N_READERS] x N_DATA_BITS  read data per port, combinational from raddr.
- waddr  in  [N_WRITERS] x $clog2(N_ENTRIES)  write address per port.
- wen  in  [N_WRITERS] x 1  write enable per port.
- wdata  in  [N_WRITERS] x N_DATA_BITS  write data per port.
- wconflict  out  1  sticky write-collision flag (see Optional Feature).

Behaviour:
- Storage: N_WRITERS x N_READERS banks, each N_ENTRIES x N_DATA_BITS, with ramstyle MLAB/no_rw_check. Writer w writes all N_READERS banks in row w. Reader p reads bank[lvt[raddr[p]]][p].
- LVT: N_ENTRIES x $clog2(N_WRITERS) flop array with N_WRITERS write ports and N_READERS combinational read ports. A write by w to address a sets lvt[a] = w.
- Initialisation FSM, states INIT and READY:
  - Reset: state=INIT, init counter=0, rdy=0, wconflict=0.
  - INIT: each cycle, write INIT_VALUE into writer-0 banks at the counter address and set lvt[counter]=0; counter increments.
  - After writing address N_ENTRIES-1: state=READY, rdy=1 on the following cycle. Init therefore takes exactly N_ENTRIES cycles after reset deasserts.
  - During INIT, user wen is ignored (no write, no LVT update, no conflict detection). rdata is undefined.
  - Reset asserted mid-INIT or mid-READY returns to INIT, counter 0, rdy low the next cycle. Contents are reinitialised.
- Write collisions: when multiple writers target the same address in one cycle, the highest-index writer wins for both data and LVT.
- OLD_DATA:
  - Writes (banks and LVT) are registered one cycle for timing.
  - A read of an address whose pending registered write matches forwards that pending data, highest pending writer winning.
  - Net effect: a read in the write cycle returns pre-write data; a read in the next cycle and later returns new data.
- NEW_DATA: a read matching a same-cycle write returns that cycle's wdata, highest matching writer winning. Otherwise it returns stored data.
- DONT_CARE: no forwarding. The same-cycle same-address read value is undefined; the next cycle returns new data.
- Latency: read 0 cycles (combinational). Write visible per the mode above.
- All rdata ports are independent; any reader may read any address concurrently, including duplicates.

Optional Feature:
- Macro: CCI_MPF_LUTRAM_MULTIPORT_CONFLICT_CHECK_EN.
- Defined: in READY, any cycle where two or more wen are high with equal waddr sets wconflict=1 on the next edge. The flag holds until reset. In simulation, a $error naming both writer indices and the address is also issued.
- Undefined: no comparators are built and wconflict is tied 0. Collision resolution (highest writer wins) is unchanged.

Test Plan:
- Init: N_ENTRIES=32, INIT_VALUE=0xA5. Deassert reset -> rdy rises exactly 32 cycles later; all 32 addresses read 0xA5 on both ports.
- Independent writers: in one cycle, w0 writes addr 3=0x11 and w1 writes addr 9=0x22 -> the next cycle, r0@3=0x11 and r1@9=0x22; a subsequent w0 write to 9=0x33 -> r1@9=0x33 (LVT switches bank).
- Collision: w0 and w1 both write addr 5 with 0x44/0x55 -> addr 5 reads 0x55; wconflict=1 with the macro, 0 without.
- Read during write: write addr 7=0xBE over old value 0x01 with a same-cycle read of 7 -> OLD_DATA returns 0x01 that cycle and 0xBE the next; NEW_DATA returns 0xBE in the same cycle.
- Reset mid-operation: after writing addr 2=0x77, assert reset 1 cycle at cycle 10 of READY -> rdy=0 next cycle, rdy again after 32 cycles, addr 2 reads INIT_VALUE, wconflict cleared.
- Degenerate config: N_WRITERS=1, N_DATA_BITS=1, N_READERS=3 -> writing addr 0=1 reads 1 on all three ports; the init value is 0 everywhere else.
